// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter with a 4:1 data mux. Four producers share one downstream
//   valid/ready channel. A grant is held for a multi-beat burst that ends with
//   req_last. A burst watchdog forces the grant to be released if a burst runs too long.
//
// Handshake: a beat transfers on any rising clk edge where out_valid and out_ready are
//   both high. req_ready[g] mirrors out_ready for the granted requester g. req_ready is
//   0 for every other requester and whenever no grant is held.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   4          requester i has a beat
//   req_last   in   4          beat of requester i ends its burst
//   req_data   in   4*WIDTH    requester i data at [i*WIDTH +: WIDTH]
//   req_ready  out  4          beat of requester i accepted this cycle
//   out_valid  out  1          downstream beat valid
//   out_last   out  1          downstream last flag
//   out_data   out  WIDTH      downstream data (0 while no grant is held)
//   out_ready  in   1          downstream accepts
//   grant_vld  out  1          a grant is held (registered; equals state==BUSY)
//   grant_idx  out  2          granted requester (registered)
//   wdog_err   out  1          one-cycle pulse following a forced release
module mux4_rr_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [3:0]         req_last,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               out_valid,
    output logic               out_last,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic               grant_vld,
    output logic [1:0]         grant_idx,
    output logic               wdog_err
);

    // The counter only has to reach MAX_BEATS-1 before it is cleared by a release.
    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic            beat;
    logic            wdog_hit;
    logic            release_now;
    logic [2:0]      idle_pick;
    logic [2:0]      rel_pick;

    // Returns {found, index} for the first set bit of vld, searched from start upward
    // (mod 4). The loop runs downward so that the lowest offset is written last and wins.
    function automatic logic [2:0] pick(input logic [3:0] vld, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (vld[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        out_valid   = grant_vld & req_valid[grant_idx];
        out_last    = grant_vld & req_last[grant_idx];
        out_data    = grant_vld ? req_data[int'(grant_idx)*WIDTH +: WIDTH] : '0;
        req_ready   = grant_vld ? ({3'b000, out_ready} << grant_idx) : 4'b0000;
        beat        = out_valid & out_ready;
        wdog_hit    = (MAX_BEATS > 0) && beat && !req_last[grant_idx] &&
                      (beat_cnt == CW'(MAX_BEATS - 1));
        release_now = beat & (req_last[grant_idx] | wdog_hit);
        idle_pick   = pick(req_valid, rr_ptr);
        // On release, the releasing requester's valid still belongs to the beat being
        // consumed. It is therefore masked here. If it is still valid next cycle, it is
        // picked up from IDLE and so ends up with lowest priority.
        rel_pick    = pick(req_valid & ~(4'b0001 << grant_idx), grant_idx + 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            beat_cnt  <= '0;
            grant_vld <= 1'b0;
            grant_idx <= 2'd0;
            wdog_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wdog_err <= 1'b0;
                    if (idle_pick[2]) begin
                        state     <= BUSY;
                        grant_vld <= 1'b1;
                        grant_idx <= idle_pick[1:0];
                        beat_cnt  <= '0;
                    end
                end
                BUSY: begin
                    wdog_err <= wdog_hit;
                    if (release_now) begin
                        rr_ptr   <= grant_idx + 2'd1;
                        beat_cnt <= '0;
                        if (rel_pick[2]) begin
                            grant_idx <= rel_pick[1:0];
                        end else begin
                            state     <= IDLE;
                            grant_vld <= 1'b0;
                            grant_idx <= 2'd0;
                        end
                    end else if (beat && (beat_cnt != {CW{1'b1}})) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_vld <= 1'b0;
                    grant_idx <= 2'd0;
                    wdog_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=8, MAX_BEATS=4).
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;
    localparam logic [31:0] DATA = {8'h44, 8'h33, 8'hA5, 8'h11};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_last;
    logic [31:0]      req_data;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic             wdog_err;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .wdog_err  (wdog_err)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        out_ready = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       rdy   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       lst   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = DATA;
        out_ready = 1'b0;
        #1;
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_wdog_err",  32'(wdog_err),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);

        // 1: single-beat burst from requester 2
        do_reset();
        req_valid = 4'b0100; req_last = 4'b0100; out_ready = 1'b1;
        tick();
        chk("t1_grant_vld", 32'(grant_vld), 32'd1);
        chk("t1_grant_idx", 32'(grant_idx), 32'd2);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_last",  32'(out_last),  32'd1);
        chk("t1_req_ready", 32'(req_ready), 32'b0100);
        chk("t1_out_data",  32'(out_data),  32'h33);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t1_idle_grant_vld", 32'(grant_vld), 32'd0);
        chk("t1_idle_out_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_req_ready", 32'(req_ready), 32'd0);
        chk("t1_idle_out_data",  32'(out_data),  32'd0);

        // 2: all four valid, single-beat bursts, back-to-back rotation
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_grant_vld", 32'(grant_vld), 32'd1);
            chk("t2_grant_idx", 32'(grant_idx), 32'(exp_g[i]));
            chk("t2_req_ready", 32'(req_ready), 32'(4'b0001 << exp_g[i]));
        end
        // Granted requester goes quiet: grant held, no beat.
        req_valid = 4'b0000;
        tick();
        tick();
        chk("t2_hold_grant_vld", 32'(grant_vld), 32'd1);
        chk("t2_hold_grant_idx", 32'(grant_idx), 32'd0);
        chk("t2_hold_out_valid", 32'(out_valid), 32'd0);

        // 3: 3-beat burst from req0 while req1 waits; out_ready toggles
        do_reset();
        req_valid = 4'b0011; req_last = 4'b0000; out_ready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            out_ready = rdy[c];
            req_last  = lst[c] ? 4'b0001 : 4'b0000;
            #1;
            chk("t3_grant_idx", 32'(grant_idx), 32'd0);
            chk("t3_out_valid", 32'(out_valid), 32'd1);
            chk("t3_req_ready", 32'(req_ready), {31'd0, rdy[c]});
            tick();
        end
        req_last = 4'b0000;
        #1;
        chk("t3_next_grant_vld", 32'(grant_vld), 32'd1);
        chk("t3_next_grant_idx", 32'(grant_idx), 32'd1);

        // 4: watchdog on req2 with MAX_BEATS=4
        do_reset();
        req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
        tick();
        chk("t4_grant_idx", 32'(grant_idx), 32'd2);
        req_valid = 4'b1100;
        for (int b = 1; b <= 3; b++) begin
            tick();
            chk("t4_busy_grant_idx", 32'(grant_idx), 32'd2);
            chk("t4_busy_wdog_err",  32'(wdog_err),  32'd0);
        end
        tick();
        chk("t4_wdog_err",   32'(wdog_err),  32'd1);
        chk("t4_grant_vld",  32'(grant_vld), 32'd1);
        chk("t4_new_grant",  32'(grant_idx), 32'd3);
        tick();
        chk("t4_wdog_pulse_end", 32'(wdog_err),  32'd0);
        chk("t4_grant_kept",     32'(grant_idx), 32'd3);

        // 5/6: reset mid-burst; data mux and pointer restart
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010; out_ready = 1'b1;
        tick();
        chk("t5_grant_idx", 32'(grant_idx), 32'd1);
        chk("t6_out_data",  32'(out_data),  32'hA5);
        req_valid = 4'b1010;
        tick();
        chk("t5_grant3_idx", 32'(grant_idx), 32'd3);
        chk("t5_out_valid",  32'(out_valid), 32'd1);
        chk("t5_out_data",   32'(out_data),  32'h44);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("t5_rst_out_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_restart_grant", 32'(grant_idx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
